// File: rtl/sap_computer.sv
// SAP-style 8-bit datapath: shared bus, A/B registers, add/sub ALU, MAR and switch-programmed RAM.
// Optional flag register enabled by defining SAP_COMPUTER_FLAGS_EN (default: cf/zf tied to 0).
module sap_computer #(
  parameter int N = 8,
  parameter int A = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] sw_dat,
  input  logic [A-1:0] sw_mar,
  input  logic         prog,
  input  logic         ai,
  input  logic         ao,
  input  logic         bi,
  input  logic         eo,
  input  logic         su,
  input  logic         fi,
  output logic [N-1:0] bus,
  output logic [N-1:0] aval,
  output logic [N-1:0] bval,
  output logic [N-1:0] aluval,
  output logic [A-1:0] marval,
  output logic         cf,
  output logic         zf
);

  logic [N-1:0] a_reg;
  logic [N-1:0] b_reg;
  logic [A-1:0] mar;
  logic [N-1:0] mem [0:(1<<A)-1];
  logic [N:0]   sum;
  logic         carry;

  // Subtract as A + ~B + 1, so carry out set means no borrow.
  assign sum    = {1'b0, a_reg} + {1'b0, (su ? ~b_reg : b_reg)} + {{N{1'b0}}, su};
  assign carry  = sum[N];
  assign aluval = sum[N-1:0];

  always_comb begin
    bus = '0;
    if (ao)         bus = a_reg;
    else if (eo)    bus = aluval;
    else if (!prog) bus = sw_dat;
    else            bus = mem[mar];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      a_reg <= '0;
      b_reg <= '0;
      mar   <= '0;
    end else begin
      if (ai) a_reg <= bus;
      if (bi) b_reg <= bus;
      mar <= sw_mar;
    end
  end

  // RAM is not affected by clr; switch writes continue during reset.
  always_ff @(posedge clk) begin
    if (!prog) mem[sw_mar] <= sw_dat;
  end

`ifdef SAP_COMPUTER_FLAGS_EN
  logic cf_reg;
  logic zf_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      cf_reg <= 1'b0;
      zf_reg <= 1'b0;
    end else if (fi) begin
      cf_reg <= carry;
      zf_reg <= (aluval == '0);
    end
  end

  assign cf = cf_reg;
  assign zf = zf_reg;
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = fi ^ carry;
  assign cf = 1'b0;
  assign zf = 1'b0;
`endif

  assign aval   = a_reg;
  assign bval   = b_reg;
  assign marval = mar;

endmodule

// File: tb/tb_sap_computer.sv
// Self-checking bench for sap_computer: directed test plan plus randomized steps against a behavioural model.
module tb_sap_computer;

`ifdef SAP_COMPUTER_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] sw_dat = '0;
  logic [3:0] sw_mar = '0;
  logic       prog = 1'b0;
  logic       ai = 1'b0, ao = 1'b0, bi = 1'b0, eo = 1'b0, su = 1'b0, fi = 1'b0;
  logic [7:0] bus, aval, bval, aluval;
  logic [3:0] marval;
  logic       cf, zf;

  int check_cnt = 0;
  int pass_cnt  = 0;

  // behavioural model state
  logic [7:0] m_a = '0, m_b = '0;
  logic [3:0] m_mar = '0;
  logic       m_cf = 1'b0, m_zf = 1'b0;
  logic [7:0] m_ram [16];
  bit         m_v [16];
  bit         chk_comb = 1'b1;

  sap_computer #(.N(8), .A(4)) dut (
    .clk(clk), .clr(clr), .sw_dat(sw_dat), .sw_mar(sw_mar), .prog(prog),
    .ai(ai), .ao(ao), .bi(bi), .eo(eo), .su(su), .fi(fi),
    .bus(bus), .aval(aval), .bval(bval), .aluval(aluval), .marval(marval),
    .cf(cf), .zf(zf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // {carry, result}: plain integer add, or subtract where carry means a >= b
  function automatic logic [8:0] alu_ref();
    int s;
    if (su) s = int'(m_a) - int'(m_b) + 256;
    else    s = int'(m_a) + int'(m_b);
    return 9'(s);
  endfunction

  task automatic step();
    logic [8:0] r;
    logic [7:0] eb;
    bit         known;
    #1;
    r = alu_ref();
    known = 1'b1;
    if (ao)         eb = m_a;
    else if (eo)    eb = r[7:0];
    else if (!prog) eb = sw_dat;
    else begin
      eb    = m_ram[m_mar];
      known = m_v[m_mar];
    end
    if (chk_comb) begin
      check("aluval", {24'b0, aluval}, {24'b0, r[7:0]});
      if (known) check("bus", {24'b0, bus}, {24'b0, eb});
    end
    if (!prog) begin
      m_ram[sw_mar] = sw_dat;
      m_v[sw_mar]   = 1'b1;
    end
    if (clr) begin
      m_a = '0; m_b = '0; m_mar = '0; m_cf = 1'b0; m_zf = 1'b0;
    end else begin
      if (ai) m_a = eb;
      if (bi) m_b = eb;
      m_mar = sw_mar;
      if (fi && FL) begin
        m_cf = r[8];
        m_zf = (r[7:0] == 8'h00);
      end
    end
    @(posedge clk);
    #1;
    check("aval", {24'b0, aval}, {24'b0, m_a});
    check("bval", {24'b0, bval}, {24'b0, m_b});
    check("marval", {28'b0, marval}, {28'b0, m_mar});
    check("cf", {31'b0, cf}, {31'b0, m_cf});
    check("zf", {31'b0, zf}, {31'b0, m_zf});
  endtask

  task automatic idle_ctl();
    ai = 0; ao = 0; bi = 0; eo = 0; su = 0; fi = 0; clr = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
    @(posedge clk);
    #1;

    // reset overrides loads
    chk_comb = 1'b0;
    clr = 1; ai = 1; bi = 1; fi = 1; prog = 0; sw_dat = 8'h5A; sw_mar = 4'h0;
    step();
    chk_comb = 1'b1;
    check("rst_aval", {24'b0, aval}, 32'h0);
    check("rst_zf", {31'b0, zf}, 32'h0);

    // program RAM and read back
    idle_ctl();
    prog = 0; sw_mar = 0; sw_dat = 8'h1E; step();
    sw_mar = 1; sw_dat = 8'h2F; step();
    sw_mar = 2; sw_dat = 8'hE0; step();
    prog = 1; sw_mar = 1; step();
    check("rd1_mar", {28'b0, marval}, 32'h1);
    check("rd1_bus", {24'b0, bus}, 32'h2F);
    sw_mar = 2; step();
    check("rd2_bus", {24'b0, bus}, 32'hE0);

    // add 5 + 3
    prog = 0; sw_mar = 4'h3; sw_dat = 8'h05; ai = 1; step();
    check("add_a", {24'b0, aval}, 32'h05);
    ai = 0; sw_dat = 8'h03; bi = 1; step();
    check("add_b", {24'b0, bval}, 32'h03);
    bi = 0; eo = 1; fi = 1; step();
    check("add_bus", {24'b0, bus}, 32'h08);
    check("add_cf", {31'b0, cf}, 32'h0);

    // subtract 5 - 3
    su = 1; step();
    check("sub_bus", {24'b0, bus}, 32'h02);
    check("sub_cf", {31'b0, cf}, {31'b0, FL});
    check("sub_zf", {31'b0, zf}, 32'h0);

    // FF + 01 wraps to zero
    idle_ctl(); sw_dat = 8'hFF; ai = 1; step();
    ai = 0; sw_dat = 8'h01; bi = 1; step();
    bi = 0; fi = 1; step();
    check("wrap_alu", {24'b0, aluval}, 32'h00);
    check("wrap_cf", {31'b0, cf}, {31'b0, FL});
    check("wrap_zf", {31'b0, zf}, {31'b0, FL});

    // 03 - 05 borrows
    idle_ctl(); sw_dat = 8'h03; ai = 1; step();
    ai = 0; sw_dat = 8'h05; bi = 1; step();
    bi = 0; su = 1; fi = 1; step();
    check("borrow_alu", {24'b0, aluval}, 32'hFE);
    check("borrow_cf", {31'b0, cf}, 32'h0);
    check("borrow_zf", {31'b0, zf}, 32'h0);

    // bus priority and A->B transfer
    idle_ctl(); ao = 1; eo = 1; #1;
    check("prio_bus", {24'b0, bus}, 32'h03);
    eo = 0; bi = 1; step();
    check("xfer_b", {24'b0, bval}, 32'h03);

    // fill RAM, then random operation
    idle_ctl(); prog = 0;
    for (int i = 0; i < 16; i++) begin
      sw_mar = 4'(i); sw_dat = 8'($urandom); step();
    end
    for (int i = 0; i < 400; i++) begin
      sw_dat = 8'($urandom);
      sw_mar = 4'($urandom);
      prog   = ($urandom_range(0, 3) != 0);
      clr    = ($urandom_range(0, 19) == 0);
      ai = 1'($urandom); ao = ($urandom_range(0, 3) == 0); bi = 1'($urandom);
      eo = 1'($urandom); su = 1'($urandom); fi = 1'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
